// File: rtl/n64_joybus_host.sv
// N64 Joybus host: serialises command bytes onto the open-drain line and decodes the device reply.
// Optional receive timeout enabled by defining JOYBUS_RX_TIMEOUT_EN.
module n64_joybus_host #(
    parameter int unsigned CLK_PER_US = 50,
    parameter int unsigned RX_THRESH  = 100
) (
    input  logic       clock,
    input  logic       reset_l,
    input  logic       start,
    input  logic [5:0] tx_len,
    input  logic [5:0] rx_len,
    input  logic [7:0] tx_data,
    output logic       tx_rd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic       line_oe,
    input  logic       line_in
);
    localparam int unsigned TO_CYC = 100 * CLK_PER_US;
    localparam int unsigned CW     = $clog2(TO_CYC + 1);
    localparam logic [CW-1:0] T1  = CW'(CLK_PER_US - 1);
    localparam logic [CW-1:0] T2  = CW'(2 * CLK_PER_US - 1);
    localparam logic [CW-1:0] T3  = CW'(3 * CLK_PER_US - 1);
    localparam logic [CW-1:0] T1M = CW'(CLK_PER_US - 2);
    localparam logic [CW-1:0] T3M = CW'(3 * CLK_PER_US - 2);
`ifdef JOYBUS_RX_TIMEOUT_EN
    localparam logic [CW-1:0] TTO = CW'(TO_CYC - 1);
`endif

    typedef enum logic [3:0] {
        IDLE, TX_LOAD, TX_LOW, TX_HIGH, STOP_LOW, STOP_HIGH,
        RX_WAIT, RX_LOW, RX_HIGH, RX_STOP, FIN
    } state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [7:0]    tx_shift, tx_shift_d;
    logic [7:0]    rx_shift, rx_shift_d;
    logic [7:0]    low_cnt, low_cnt_d;
    logic [7:0]    rx_data_d;
    logic [5:0]    tx_left, tx_left_d;
    logic [5:0]    rx_left, rx_left_d;
    logic [2:0]    bit_cnt, bit_cnt_d;
    logic          rx_valid_d, error_d, rx_bit;
    logic [1:0]    sync;
    logic          prev;
    logic          fall, rise;

    assign fall = prev & ~sync[1];
    assign rise = ~prev & sync[1];

    // Line synchroniser plus one history flop for edge detection
    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            sync <= 2'b11;
            prev <= 1'b1;
        end else begin
            sync <= {sync[0], line_in};
            prev <= sync[1];
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d    = state;
        cnt_d      = cnt + CW'(1);
        tx_shift_d = tx_shift;
        rx_shift_d = rx_shift;
        low_cnt_d  = low_cnt;
        rx_data_d  = rx_data;
        tx_left_d  = tx_left;
        rx_left_d  = rx_left;
        bit_cnt_d  = bit_cnt;
        rx_valid_d = 1'b0;
        error_d    = error;
        rx_bit     = 1'b0;
        case (state)
            IDLE: begin
                cnt_d = '0;
                if (start) begin
                    error_d   = (tx_len == 6'd0);
                    tx_left_d = tx_len;
                    rx_left_d = rx_len;
                    state_d   = (tx_len == 6'd0) ? FIN : TX_LOAD;
                end
            end
            TX_LOAD: begin
                tx_shift_d = tx_data;
                tx_left_d  = tx_left - 6'd1;
                bit_cnt_d  = 3'd0;
                cnt_d      = '0;
                state_d    = TX_LOW;
            end
            TX_LOW: begin
                if (cnt == (tx_shift[7] ? T1 : T3)) begin
                    cnt_d   = '0;
                    state_d = TX_HIGH;
                end
            end
            TX_HIGH: begin
                // Last bit before a reload ends one cycle early so TX_LOAD completes the cell
                if (bit_cnt != 3'd7) begin
                    if (cnt == (tx_shift[7] ? T3 : T1)) begin
                        cnt_d      = '0;
                        tx_shift_d = {tx_shift[6:0], 1'b0};
                        bit_cnt_d  = bit_cnt + 3'd1;
                        state_d    = TX_LOW;
                    end
                end else if (tx_left != 6'd0) begin
                    if (cnt == (tx_shift[7] ? T3M : T1M)) begin
                        cnt_d   = '0;
                        state_d = TX_LOAD;
                    end
                end else if (cnt == (tx_shift[7] ? T3 : T1)) begin
                    cnt_d   = '0;
                    state_d = STOP_LOW;
                end
            end
            STOP_LOW: begin
                if (cnt == T1) begin
                    cnt_d   = '0;
                    state_d = STOP_HIGH;
                end
            end
            STOP_HIGH: begin
                if (cnt == T2) begin
                    cnt_d     = '0;
                    bit_cnt_d = 3'd0;
                    state_d   = (rx_left == 6'd0) ? FIN : RX_WAIT;
                end
            end
            RX_WAIT, RX_HIGH: begin
                if (fall) begin
                    cnt_d     = '0;
                    low_cnt_d = 8'd1;
                    state_d   = RX_LOW;
                end
`ifdef JOYBUS_RX_TIMEOUT_EN
                else if (cnt == TTO) begin
                    state_d = FIN;
                    error_d = 1'b1;
                end
`endif
            end
            RX_LOW: begin
                if (rise) begin
                    rx_bit     = (32'(low_cnt) < RX_THRESH);
                    rx_shift_d = {rx_shift[6:0], rx_bit};
                    bit_cnt_d  = bit_cnt + 3'd1;
                    cnt_d      = '0;
                    state_d    = RX_HIGH;
                    if (bit_cnt == 3'd7) begin
                        rx_data_d  = {rx_shift[6:0], rx_bit};
                        rx_valid_d = 1'b1;
                        rx_left_d  = rx_left - 6'd1;
                        if (rx_left == 6'd1) state_d = RX_STOP;
                    end
                end else begin
                    if (low_cnt != 8'hFF) low_cnt_d = low_cnt + 8'd1;
`ifdef JOYBUS_RX_TIMEOUT_EN
                    if (cnt == TTO) begin
                        state_d = FIN;
                        error_d = 1'b1;
                    end
`endif
                end
            end
            RX_STOP: begin
                if (rise) state_d = FIN;
`ifdef JOYBUS_RX_TIMEOUT_EN
                else if (fall) cnt_d = '0;
                else if (cnt == TTO) begin
                    state_d = FIN;
                    error_d = 1'b1;
                end
`endif
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, datapath and registered outputs decoded from the next state
    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            state    <= IDLE;
            cnt      <= '0;
            tx_shift <= 8'd0;
            rx_shift <= 8'd0;
            low_cnt  <= 8'd0;
            tx_left  <= 6'd0;
            rx_left  <= 6'd0;
            bit_cnt  <= 3'd0;
            rx_data  <= 8'd0;
            rx_valid <= 1'b0;
            error    <= 1'b0;
            tx_rd    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            line_oe  <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            tx_shift <= tx_shift_d;
            rx_shift <= rx_shift_d;
            low_cnt  <= low_cnt_d;
            tx_left  <= tx_left_d;
            rx_left  <= rx_left_d;
            bit_cnt  <= bit_cnt_d;
            rx_data  <= rx_data_d;
            rx_valid <= rx_valid_d;
            error    <= error_d;
            tx_rd    <= (state_d == TX_LOAD);
            busy     <= (state_d != IDLE) && (state_d != FIN);
            done     <= (state_d == FIN);
            line_oe  <= (state_d == TX_LOW) || (state_d == STOP_LOW);
        end
    end
endmodule

// File: tb/tb_n64_joybus_host.sv
// Self-checking bench for n64_joybus_host: line timing, reply decoding, error and reset cases.
module tb_n64_joybus_host;
    localparam int C   = 50;
    localparam int THR = 100;

    logic       clock = 1'b0;
    logic       reset_l = 1'b0;
    logic       start = 1'b0;
    logic [5:0] tx_len = 6'd0;
    logic [5:0] rx_len = 6'd0;
    logic [7:0] tx_data;
    logic       tx_rd;
    logic [7:0] rx_data;
    logic       rx_valid, busy, done, error, line_oe;
    logic       line_in;
    logic       dev_low = 1'b0;

    logic [7:0] tx_bytes [0:3];
    logic [1:0] tx_idx = 2'd0;

    int total = 0;
    int bad = 0;
    int exp_low[$];
    int exp_period[$];
    logic [7:0] exp_rx[$];

    int   run = 0, since_rise = 0, p = 0;
    int   oe_falls = 0, tx_rd_cnt = 0, done_cnt = 0;
    logic oe_q = 1'b0, have_rise = 1'b0, last_err = 1'b0;
    logic [7:0] e8;

    assign line_in = ~(line_oe | dev_low);
    assign tx_data = tx_bytes[tx_idx];

    always #5 clock = ~clock;

    n64_joybus_host #(.CLK_PER_US(C), .RX_THRESH(THR)) dut (
        .clock(clock), .reset_l(reset_l), .start(start), .tx_len(tx_len),
        .rx_len(rx_len), .tx_data(tx_data), .tx_rd(tx_rd), .rx_data(rx_data),
        .rx_valid(rx_valid), .busy(busy), .done(done), .error(error),
        .line_oe(line_oe), .line_in(line_in)
    );

    // Upstream byte source: restart on accepted start, advance on tx_rd
    always @(posedge clock) begin
        if (start && !busy) tx_idx <= 2'd0;
        else if (tx_rd)     tx_idx <= tx_idx + 2'd1;
    end

    // Line timing and receive scoreboard
    always @(negedge clock) begin
        if (!reset_l) begin
            oe_q = 1'b0; run = 0; since_rise = 0; have_rise = 1'b0;
        end else begin
            if (!busy) have_rise = 1'b0;
            if (line_oe && !oe_q) begin
                if (have_rise) begin
                    total++;
                    if (exp_period.size() == 0) begin
                        bad++; $display("FAIL cell_period: unexpected cell of %0d cycles", since_rise);
                    end else begin
                        p = exp_period.pop_front();
                        if (since_rise !== p) begin
                            bad++; $display("FAIL cell_period: got %0d want %0d", since_rise, p);
                        end
                    end
                end
                have_rise = 1'b1; since_rise = 0; run = 0;
            end
            if (!line_oe && oe_q) begin
                oe_falls++;
                total++;
                if (exp_low.size() == 0) begin
                    bad++; $display("FAIL low_width: unexpected low of %0d cycles", run);
                end else begin
                    p = exp_low.pop_front();
                    if (run !== p) begin
                        bad++; $display("FAIL low_width: got %0d want %0d", run, p);
                    end
                end
            end
            if (line_oe) run++;
            since_rise++;
            if (tx_rd) tx_rd_cnt++;
            if (done) begin done_cnt++; last_err = error; end
            if (rx_valid) begin
                total++;
                if (exp_rx.size() == 0) begin
                    bad++; $display("FAIL rx_byte: unexpected byte %02h", rx_data);
                end else begin
                    e8 = exp_rx.pop_front();
                    if (rx_data !== e8) begin
                        bad++; $display("FAIL rx_byte: got %02h want %02h", rx_data, e8);
                    end
                end
            end
            oe_q = line_oe;
        end
    end

    task automatic push_tx(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            exp_low.push_back(b[i] ? C : 3 * C);
            exp_period.push_back(4 * C);
        end
    endtask

    task automatic do_start(input logic [5:0] tl, input logic [5:0] rl);
        @(posedge clock); #1;
        start = 1'b1; tx_len = tl; rx_len = rl;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic dev_pulse(input int lo, input int hi);
        @(posedge clock); #1 dev_low = 1'b1;
        repeat (lo) @(posedge clock);
        #1 dev_low = 1'b0;
        repeat (hi) @(posedge clock);
    endtask

    task automatic dev_byte(input logic [7:0] b);
        exp_rx.push_back(b);
        for (int i = 7; i >= 0; i--) dev_pulse(b[i] ? C : 3 * C, b[i] ? 3 * C : C);
    endtask

    task automatic wait_falls(input int target, input string name);
        logic ok = 1'b0;
        for (int i = 0; i < 40000; i++) begin
            @(posedge clock);
            if (oe_falls >= target) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL %s_tx_end: falls=%0d want %0d", name, oe_falls, target);
        end
    endtask

    task automatic wait_done(input string name, input logic exp_err, input int base);
        logic ok = 1'b0;
        for (int i = 0; i < 40000; i++) begin
            @(posedge clock);
            if (done_cnt > base) begin ok = 1'b1; break; end
        end
        total++;
        if (!ok) begin
            bad++; $display("FAIL %s_done: no done, want done error=%0d", name, exp_err);
        end else if (last_err !== exp_err) begin
            bad++; $display("FAIL %s_error: got %0d want %0d", name, last_err, exp_err);
        end
    endtask

    task automatic check_drained(input string name);
        total++;
        if (exp_low.size() != 0 || exp_period.size() != 0 || exp_rx.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: left low=%0d period=%0d rx=%0d want 0/0/0",
                     name, exp_low.size(), exp_period.size(), exp_rx.size());
        end
    endtask

    // Full transaction: bytes packed MSB-first in the 32-bit words
    task automatic do_txn(input string name, input int ntx, input logic [31:0] txw,
                          input int nrx, input logic [31:0] rxw);
        int bd = done_cnt, bf = oe_falls, br = tx_rd_cnt;
        for (int i = 0; i < ntx; i++) begin
            tx_bytes[i] = txw[31 - 8 * i -: 8];
            push_tx(txw[31 - 8 * i -: 8]);
        end
        exp_low.push_back(C);
        do_start(6'(ntx), 6'(nrx));
        if (nrx > 0) begin
            wait_falls(bf + 8 * ntx + 1, name);
            repeat (120) @(posedge clock);
            for (int j = 0; j < nrx; j++) dev_byte(rxw[31 - 8 * j -: 8]);
            dev_pulse(C, 10);
        end
        wait_done(name, 1'b0, bd);
        total++;
        if (tx_rd_cnt - br !== ntx) begin
            bad++; $display("FAIL %s_tx_rd: got %0d want %0d", name, tx_rd_cnt - br, ntx);
        end
        check_drained(name);
    endtask

    task automatic test_reset;
        #3;
        total++;
        if ({line_oe, busy, done, error, tx_rd, rx_valid, rx_data} !== 14'd0) begin
            bad++; $display("FAIL reset_outputs: got %014b want 0", {line_oe, busy, done, error, tx_rd, rx_valid, rx_data});
        end
        repeat (3) @(negedge clock);
        reset_l = 1'b1;
        repeat (3) @(negedge clock);
        total++;
        if ({line_oe, busy, done, error} !== 4'd0) begin
            bad++; $display("FAIL idle_after_reset: got %04b want 0000", {line_oe, busy, done, error});
        end
    endtask

    task automatic test_status;
        do_txn("status", 1, 32'h01000000, 4, 32'h00050001);
    endtask

    task automatic test_busy_and_zero;
        int bd = done_cnt;
        tx_bytes[0] = 8'h5A; push_tx(8'h5A); exp_low.push_back(C);
        do_start(6'd1, 6'd0);
        repeat (300) @(posedge clock);
        #1 start = 1'b1; tx_len = 6'd0;
        @(posedge clock); #1 start = 1'b0;
        total++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            bad++; $display("FAIL start_while_busy: busy=%0d done=%0d want 1/0", busy, done);
        end
        wait_done("busy_txn", 1'b0, bd);
        check_drained("busy_txn");
        do_start(6'd0, 6'd0);
        total++;
        if ({done, error, line_oe, busy} !== 4'b1100) begin
            bad++; $display("FAIL zero_len: done/error/oe/busy=%04b want 1100", {done, error, line_oe, busy});
        end
        @(posedge clock); #1;
        total++;
        if (done !== 1'b0 || error !== 1'b1) begin
            bad++; $display("FAIL zero_len_after: done=%0d error=%0d want 0/1", done, error);
        end
    endtask

    task automatic test_multi_tx;
        int bd = done_cnt, br = tx_rd_cnt;
        tx_bytes[0] = 8'h02; tx_bytes[1] = 8'h80; tx_bytes[2] = 8'h01;
        push_tx(8'h02); push_tx(8'h80); push_tx(8'h01); exp_low.push_back(C);
        do_start(6'd3, 6'd0);
        total++;
        if (error !== 1'b0) begin
            bad++; $display("FAIL error_clear: got %0d want 0", error);
        end
        wait_done("multi", 1'b0, bd);
        total++;
        if (tx_rd_cnt - br !== 3) begin
            bad++; $display("FAIL multi_tx_rd: got %0d want 3", tx_rd_cnt - br);
        end
        check_drained("multi");
    endtask

    task automatic test_threshold;
        int w[8] = '{99, 100, 99, 100, 300, 20, 260, 149};
        logic [7:0] exp_b = 8'd0;
        int bd = done_cnt, bf = oe_falls;
        tx_bytes[0] = 8'h00; push_tx(8'h00); exp_low.push_back(C);
        for (int i = 0; i < 8; i++) exp_b = {exp_b[6:0], (w[i] < THR) ? 1'b1 : 1'b0};
        exp_rx.push_back(exp_b);
        do_start(6'd1, 6'd1);
        wait_falls(bf + 9, "thresh");
        repeat (120) @(posedge clock);
        for (int i = 0; i < 8; i++) dev_pulse(w[i], C);
        dev_pulse(7, 10);
        wait_done("thresh", 1'b0, bd);
        check_drained("thresh");
    endtask

    task automatic test_reset_mid;
        logic ok = 1'b0;
        tx_bytes[0] = 8'h00; push_tx(8'h00); exp_low.push_back(C);
        do_start(6'd1, 6'd0);
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (line_oe) begin ok = 1'b1; break; end
        end
        total++;
        if (!ok) begin
            bad++; $display("FAIL reset_mid_reach: line_oe=%0d want 1", line_oe);
        end
        #2 reset_l = 1'b0;
        #1;
        total++;
        if ({line_oe, busy, done, tx_rd, rx_valid} !== 5'd0) begin
            bad++; $display("FAIL reset_mid: got %05b want 00000", {line_oe, busy, done, tx_rd, rx_valid});
        end
        exp_low.delete(); exp_period.delete(); exp_rx.delete();
        repeat (3) @(negedge clock);
        reset_l = 1'b1;
        do_txn("after_reset", 1, 32'h01000000, 2, 32'h3CC30000);
    endtask

`ifdef JOYBUS_RX_TIMEOUT_EN
    task automatic test_timeout;
        int bd = done_cnt, bf = oe_falls, n = 0;
        logic ok = 1'b0;
        tx_bytes[0] = 8'h01; push_tx(8'h01); exp_low.push_back(C);
        do_start(6'd1, 6'd1);
        wait_falls(bf + 9, "timeout");
        for (int i = 0; i < 8000; i++) begin
            @(negedge clock);
            n++;
            if (done) begin ok = 1'b1; break; end
        end
        total++;
        if (!ok || n !== 2 * C + 100 * C || error !== 1'b1) begin
            bad++; $display("FAIL rx_timeout: cycles=%0d error=%0d want %0d/1", n, error, 2 * C + 100 * C);
        end
        wait_done("timeout", 1'b1, bd);
        check_drained("timeout");
    endtask
`endif

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 4; i++) tx_bytes[i] = 8'h00;
        test_reset;
        test_status;
        test_busy_and_zero;
        test_multi_tx;
        test_threshold;
        test_reset_mid;
`ifdef JOYBUS_RX_TIMEOUT_EN
        test_timeout;
`endif
        repeat (5) @(posedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/n64_joybus_host.md
N64_JOYBUS_HOST -- requirements
Module: n64_joybus_host

Interface
REQ-001 SHALL have parameter CLK_PER_US, default 50, clock cycles per microsecond.
REQ-002 SHALL have parameter RX_THRESH, default 100, low-pulse cycle count at or above which a received bit decodes as 0.
REQ-003 clock  input  1  system clock, all logic on rising edge.
REQ-004 reset_l  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle pulse that begins a transaction; ignored unless busy=0.
REQ-006 tx_len  input  6  number of command bytes to send (1-63), sampled on start.
REQ-007 rx_len  input  6  number of response bytes to receive (0-63), sampled on start.
REQ-008 tx_data  input  8  next command byte, valid whenever busy=1 and a byte is pending.
REQ-009 tx_rd  output  1  one-cycle pulse when tx_data is loaded; upstream presents the next byte from the following cycle.
REQ-010 rx_data  output  8  received byte, valid while rx_valid=1.
REQ-011 rx_valid  output  1  one-cycle pulse per completed received byte.
REQ-012 busy  output  1  high from the cycle after start until the cycle done pulses.
REQ-013 done  output  1  one-cycle pulse at transaction end.
REQ-014 error  output  1  set with done when the transaction ended abnormally; cleared on the next accepted start.
REQ-015 line_oe  output  1  1 = drive bus low (open-drain); 0 = release.
REQ-016 line_in  input  1  raw bus level, asynchronous.

Function
REQ-017 line_in SHALL pass through a 2-flop synchronizer; all edge detection uses the synchronized value.
REQ-018 States SHALL be IDLE, TX_LOAD, TX_LOW, TX_HIGH, STOP_LOW, STOP_HIGH, RX_WAIT, RX_LOW, RX_HIGH, RX_STOP, FIN.
REQ-019 IDLE->TX_LOAD on start; TX_LOAD pulses tx_rd, loads tx_data into an 8-bit shift register MSB first, then goes to TX_LOW.
REQ-020 Bit 0 SHALL be 3*CLK_PER_US cycles low then 1*CLK_PER_US high; bit 1 SHALL be 1*CLK_PER_US low then 3*CLK_PER_US high (150/50 and 50/150 at default).
REQ-021 After the 8th bit of a byte: more bytes -> TX_LOAD; else -> STOP_LOW.
REQ-022 Host stop bit: STOP_LOW drives low CLK_PER_US cycles; STOP_HIGH releases for 2*CLK_PER_US cycles; then RX_WAIT, or FIN if rx_len=0.
REQ-023 RX_WAIT->RX_LOW on a synchronized falling edge; RX_LOW counts low cycles until the rising edge, then decodes bit = (count < RX_THRESH) ? 1 : 0, shifts MSB first, enters RX_HIGH.
REQ-024 After every 8 decoded bits, rx_data SHALL update and rx_valid SHALL pulse in the cycle following the rising edge.
REQ-025 After rx_len bytes, RX_STOP SHALL consume one further low pulse (device stop bit) regardless of width; its rising edge -> FIN.
REQ-026 FIN SHALL pulse done for one cycle, return to IDLE, deassert busy the same cycle.
REQ-027 line_oe SHALL be 0 in every state except TX_LOW and STOP_LOW.
REQ-028 Low-width counter SHALL saturate at 255, never wrap.
REQ-029 start while busy=1 SHALL be ignored with no state change.
REQ-030 tx_len=0 on start SHALL produce done with error=1 next cycle, line untouched.

Reset
REQ-031 reset_l low SHALL immediately force IDLE, line_oe=0, busy=0, done=0, error=0, tx_rd=0, rx_valid=0, rx_data=0, counters cleared, synchronizer flops=1.
REQ-032 Reset mid-transaction SHALL release the bus within the same asynchronous assertion; no partial done or rx_valid emitted.

Configuration
REQ-033 Macro JOYBUS_RX_TIMEOUT_EN defined: in RX_WAIT, RX_HIGH, RX_STOP, no falling/rising edge for 100*CLK_PER_US cycles -> FIN with error=1; RX_LOW exceeding the same limit likewise.
REQ-034 Macro undefined: no timeout logic; receive states wait indefinitely; error only from REQ-030.

Verification
REQ-035 start, tx_len=1, tx_data=0x01, rx_len=4; model replies 0x00,0x05,0x00,0x01 + stop -> line_oe low 150/50/150/.../low 50 pattern, four rx_valid with those bytes, done, error=0.
REQ-036 tx_len=3 bytes 0x02,0x80,0x01 -> three tx_rd pulses, 24 bit cells each 200 cycles, stop bit 50 low.
REQ-037 device low pulse 99 cycles -> bit 1; 100 cycles -> bit 0.
REQ-038 With JOYBUS_RX_TIMEOUT_EN, no device reply -> done with error=1 exactly 5000 cycles after RX_WAIT entry, rx_valid never pulses.
REQ-039 reset_l asserted during TX_LOW -> line_oe=0 immediately, busy=0; subsequent start completes normally.
REQ-040 start while busy and tx_len=0 start -> first ignored; second gives done+error next cycle with line_oe=0.
